// File: rtl/mult_accum_pipelined.sv
// Block accumulator behind the multiplier: sums BLOCK_LEN products (or fewer on flush)
// with saturation and hands each sum to the sink through a one-entry valid/ready buffer.
module mult_accum_pipelined #(
    parameter int DATA_WIDTH = 2,
    parameter int ACC_WIDTH  = 8,
    parameter int BLOCK_LEN  = 4,
    parameter int CNT_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_flush,
    output logic                  in_ready,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic [CNT_W-1:0]      out_count,
    output logic                  out_ovf
);

    typedef enum logic {ACCUM = 1'b0, FULL = 1'b1} state_t;

    state_t                state_q, state_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ovf_acc_q, ovf_acc_d;
    logic [ACC_WIDTH-1:0]  out_data_q, out_data_d;
    logic [CNT_W-1:0]      out_count_q, out_count_d;
    logic                  out_ovf_q, out_ovf_d;

    logic                  accept, flush, close, sat;
    logic [DATA_WIDTH-1:0] add;
    logic [ACC_WIDTH:0]    sum;
    logic [ACC_WIDTH-1:0]  nxt;

    assign in_ready  = (state_q == ACCUM) || out_ready;
    assign out_valid = (state_q == FULL);
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

    always_comb begin
        accept = in_valid && in_ready;
        flush  = in_flush && in_ready;
        // Gate the addend so a stalled or idle in_data never reaches the sum.
        add    = accept ? in_data : '0;
        sum    = {1'b0, acc_q} + (ACC_WIDTH+1)'(add);
        sat    = sum[ACC_WIDTH];
        nxt    = sat ? '1 : sum[ACC_WIDTH-1:0];
        close  = (accept && (cnt_q == CNT_W'(BLOCK_LEN - 1)))
              || (flush && ((cnt_q != '0) || accept));

        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_acc_d   = ovf_acc_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        if (close) begin
            // A close while draining reloads the buffer, so out_valid stays high.
            state_d     = FULL;
            out_data_d  = nxt;
            out_count_d = cnt_q + CNT_W'(accept);
            out_ovf_d   = ovf_acc_q | sat;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_acc_d   = 1'b0;
        end else begin
            if (accept) begin
                acc_d     = nxt;
                cnt_d     = cnt_q + 1'b1;
                ovf_acc_d = ovf_acc_q | sat;
            end
            if (state_q == FULL && out_ready) state_d = ACCUM;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_acc_q   <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_acc_q   <= ovf_acc_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

endmodule
